// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard, forwarding and halt-drain controller that sits beside the ID stage.
// A shadow scoreboard mirrors the register writes in flight behind ID and is
// used to raise stall/bubble/flush, to pick the EX-stage forwarding source
// for each operand, and to drain the pipeline after an HLT before asserting
// a sticky halt.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               ID source specifiers
//   id_rs_used, id_rt_used     source actually read
//   id_rd                      ID destination
//   id_regwrite, id_memread,
//   id_hlt                     ID decode flags
//   br_taken                   registered taken-branch from EX
//   mem_stall                  global freeze request
//   stall, bubble, flush       combinational pipeline controls
//   fwd_a, fwd_b               registered EX forward selects (0 = regfile,
//                              k = result of shadow stage k)
//   hlt                        registered, sticky halt
//   stall_cnt                  saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int REG_W    = 4,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16,
  localparam int FWD_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_hlt,
  input  logic             br_taken,
  input  logic             mem_stall,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic             hlt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  // Only stages 1..DEPTH-1 are stored: the register file is write-through,
  // so the entry at stage DEPTH can never be a forwarding source.
  logic             v_reg  [1:DEPTH-1];
  logic [REG_W-1:0] rd_reg [1:DEPTH-1];
  logic             rw_reg [1:DEPTH-1];
  logic             ld_reg [1:DEPTH-1];
  logic             hl1_reg;          // HLT flag of the stage-1 entry

  state_t           state_reg;
  logic [FWD_W-1:0] drain_cnt_reg;
  logic [FWD_W-1:0] fwd_a_reg, fwd_b_reg;
  logic             hlt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  logic [DEPTH-1:1] match_a, match_b;
  logic [FWD_W-1:0] sel_a, sel_b;
  logic             hz_a, hz_b;
  logic             hz_stall, hold, advance, ins_v;

  // Per-stage source matches; register 0 is excluded when hardwired zero.
  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_match
      assign match_a[gi] = v_reg[gi] && rw_reg[gi] && (rd_reg[gi] == id_rs) &&
                           id_rs_used && !((ZERO_REG != 0) && (id_rs == '0));
      assign match_b[gi] = v_reg[gi] && rw_reg[gi] && (rd_reg[gi] == id_rt) &&
                           id_rt_used && !((ZERO_REG != 0) && (id_rt == '0));
    end
  endgenerate

  // Youngest match wins: scan oldest to youngest so the smallest k is last.
  // The producer will be one stage further on when the consumer reaches EX,
  // hence k+1. ALU results are ready at stage 2 so they never stall; a load
  // is ready at 2+LOAD_LAT.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    hz_a  = 1'b0;
    hz_b  = 1'b0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (match_a[k]) begin
        sel_a = FWD_W'(k + 1);
        hz_a  = ld_reg[k] && ((k + 1) < (2 + LOAD_LAT));
      end
      if (match_b[k]) begin
        sel_b = FWD_W'(k + 1);
        hz_b  = ld_reg[k] && ((k + 1) < (2 + LOAD_LAT));
      end
    end
  end

  assign hz_stall = (state_reg == RUN) && id_valid && (hz_a || hz_b);
  // Anything that keeps ID from advancing, below freeze and flush priority.
  assign hold     = (state_reg != RUN) || hz_stall;
  assign advance  = !mem_stall && !br_taken && !hold;
  assign ins_v    = advance && id_valid;

  assign stall  = mem_stall || (!br_taken && hold);
  assign bubble = !mem_stall && !br_taken && hold;
  assign flush  = !mem_stall && br_taken;

  // Shadow scoreboard shift; frozen by mem_stall. A flush discards the old
  // stage-1 entry as it moves to stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < DEPTH; k++) begin
        v_reg[k]  <= 1'b0;
        rd_reg[k] <= '0;
        rw_reg[k] <= 1'b0;
        ld_reg[k] <= 1'b0;
      end
      hl1_reg <= 1'b0;
    end else if (!mem_stall) begin
      for (int k = DEPTH - 1; k >= 2; k--) begin
        v_reg[k]  <= (k == 2) ? (v_reg[1] && !br_taken) : v_reg[k-1];
        rd_reg[k] <= rd_reg[k-1];
        rw_reg[k] <= rw_reg[k-1];
        ld_reg[k] <= ld_reg[k-1];
      end
      v_reg[1]  <= ins_v;
      rd_reg[1] <= id_rd;
      rw_reg[1] <= id_regwrite;
      ld_reg[1] <= id_memread;
      hl1_reg   <= id_hlt;
    end
  end

  // Forward selects, hazard counter and halt FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      fwd_a_reg     <= '0;
      fwd_b_reg     <= '0;
      hlt_reg       <= 1'b0;
      stall_cnt_reg <= '0;
    end else if (!mem_stall) begin
      fwd_a_reg <= advance ? sel_a : '0;
      fwd_b_reg <= advance ? sel_b : '0;
      if (hz_stall && !br_taken && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      case (state_reg)
        RUN: begin
          if (ins_v && id_hlt) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= FWD_W'(DEPTH);
          end
        end
        DRAIN: begin
          if (br_taken && v_reg[1] && hl1_reg) begin
            // Speculative HLT killed while still at stage 1.
            state_reg     <= RUN;
            drain_cnt_reg <= '0;
          end else if (drain_cnt_reg == FWD_W'(1)) begin
            state_reg     <= HALTED;
            drain_cnt_reg <= '0;
            hlt_reg       <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - FWD_W'(1);
          end
        end
        HALTED:  hlt_reg   <= 1'b1;
        default: state_reg <= RUN;
      endcase
    end
  end

  assign fwd_a     = fwd_a_reg;
  assign fwd_b     = fwd_b_reg;
  assign hlt       = hlt_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Directed bench for pipe_hazard_unit. The main instance uses the default
// parameters (DEPTH=3, LOAD_LAT=1); a second instance with LOAD_LAT=0 shares
// the same stimulus to show the load-use case without a stall.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       id_rs_used, id_rt_used;
  logic       id_regwrite, id_memread, id_hlt;
  logic       br_taken, mem_stall;

  logic        stall, bubble, flush, hlt;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  logic        z_stall, z_bubble, z_flush, z_hlt;
  logic [1:0]  z_fwd_a, z_fwd_b;
  logic [15:0] z_stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_hlt(id_hlt),
    .br_taken(br_taken), .mem_stall(mem_stall),
    .stall(stall), .bubble(bubble), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .hlt(hlt), .stall_cnt(stall_cnt)
  );

  pipe_hazard_unit #(.LOAD_LAT(0)) dut_ll0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_hlt(id_hlt),
    .br_taken(br_taken), .mem_stall(mem_stall),
    .stall(z_stall), .bubble(z_bubble), .flush(z_flush),
    .fwd_a(z_fwd_a), .fwd_b(z_fwd_b), .hlt(z_hlt), .stall_cnt(z_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                       input logic rsu, input logic rtu, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic hl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_hlt = hl;
    $display("t=%0t ID v=%0b rs=%0d rt=%0d use=%0b%0b rd=%0d rw=%0b ld=%0b hlt=%0b br=%0b ms=%0b",
             $time, v, rs, rt, rsu, rtu, rd, rw, mr, hl, br_taken, mem_stall);
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    nop();
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; br_taken = 1'b0; mem_stall = 1'b0;
    nop();
    repeat (2) tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble got %0b want 0", bubble); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0b want 0", flush); end
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL rst_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
    checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL rst_hlt got %0b want 0", hlt); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", stall_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_chain();
    idle(3);
    drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);   // ADD r1=r2+r3
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu1_stall got %0b want 0", stall); end
    tick();
    drive(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);   // ADD r2=r1+r3
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu2_stall got %0b want 0", stall); end
    tick();
    checks++; if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin errors++; $display("FAIL alu2_fwd got %0d/%0d want 2/0", fwd_a, fwd_b); end
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);   // SUB r4=r1-r2
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu3_stall got %0b want 0", stall); end
    tick();
    checks++; if (fwd_a !== 2'd3 || fwd_b !== 2'd2) begin errors++; $display("FAIL alu3_fwd got %0d/%0d want 3/2", fwd_a, fwd_b); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL alu_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    idle(3);
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);   // LW r5
    tick();
    drive(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);   // ADD r6=r5+r5
    #1;
    checks++; if (stall !== 1'b1 || bubble !== 1'b1) begin errors++; $display("FAIL lu_hz got stall=%0b bubble=%0b want 1/1", stall, bubble); end
    checks++; if (z_stall !== 1'b0) begin errors++; $display("FAIL lu0_stall got %0b want 0", z_stall); end
    tick();
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL lu_bubble_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
    checks++; if (z_fwd_a !== 2'd2 || z_fwd_b !== 2'd2) begin errors++; $display("FAIL lu0_fwd got %0d/%0d want 2/2", z_fwd_a, z_fwd_b); end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got stall=%0b want 0", stall); end
    tick();
    checks++; if (fwd_a !== 2'd3 || fwd_b !== 2'd3) begin errors++; $display("FAIL lu_fwd got %0d/%0d want 3/3", fwd_a, fwd_b); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt2 got %0d want 1", stall_cnt); end
  endtask

  task automatic test_zero_unused();
    idle(3);
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);   // LW r0
    tick();
    drive(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);   // ADD r7=r0+r0
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %0b want 0", stall); end
    tick();
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL r0_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
    drive(1'b1, 4'd7, 4'd7, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);   // rt unused
    tick();
    checks++; if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin errors++; $display("FAIL unused_fwd got %0d/%0d want 2/0", fwd_a, fwd_b); end
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1, 1'b0);   // LW r9
    tick();
    drive(1'b1, 4'd9, 4'd2, 1'b0, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0);  // rs=r9 unused
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unused_ld_stall got %0b want 0", stall); end
    tick();
    checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL unused_ld_fwd got %0d want 0", fwd_a); end
  endtask

  task automatic test_branch_flush();
    idle(3);
    drive(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);   // LW r5
    tick();
    br_taken = 1'b1;
    drive(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (flush !== 1'b1 || stall !== 1'b0 || bubble !== 1'b0) begin errors++; $display("FAIL br_ctl got flush=%0b stall=%0b bubble=%0b want 1/0/0", flush, stall, bubble); end
    tick();
    br_taken = 1'b0;
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL br_cnt got %0d want 1", stall_cnt); end
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL br_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
    drive(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_killed_stall got %0b want 0", stall); end
    tick();
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL br_killed_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
  endtask

  task automatic test_halt_clean();
    idle(3);
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);   // HLT
    tick();                                                          // HLT leaves ID
    nop();
    #1;
    checks++; if (stall !== 1'b1 || bubble !== 1'b1) begin errors++; $display("FAIL hlt_drain got stall=%0b bubble=%0b want 1/1", stall, bubble); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++; if (hlt !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL hlt_early%0d got hlt=%0b stall=%0b want 0/1", i, hlt, stall); end
    end
    tick();
    checks++; if (hlt !== 1'b1 || stall !== 1'b1 || bubble !== 1'b1) begin errors++; $display("FAIL hlt_rise got hlt=%0b stall=%0b bubble=%0b want 1/1/1", hlt, stall, bubble); end
    tick();
    checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL hlt_sticky got %0b want 1", hlt); end
    rst_n = 1'b0;
    #1;
    checks++; if (hlt !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL hlt_reset got hlt=%0b stall=%0b want 0/0", hlt, stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_halt_flush();
    idle(3);
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);   // speculative HLT
    tick();
    br_taken = 1'b1;
    nop();
    #1;
    checks++; if (flush !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL hf_ctl got flush=%0b stall=%0b want 1/0", flush, stall); end
    tick();
    br_taken = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL hf_run got stall=%0b want 0", stall); end
    repeat (4) tick();
    checks++; if (hlt !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL hf_nohalt got hlt=%0b stall=%0b want 0/0", hlt, stall); end
  endtask

  task automatic test_mem_stall();
    idle(3);
    drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    tick();
    mem_stall = 1'b1;
    drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall !== 1'b1 || bubble !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL ms_ctl got %0b/%0b/%0b want 1/0/0", stall, bubble, flush); end
    repeat (4) tick();
    checks++; if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin errors++; $display("FAIL ms_hold got %0d/%0d want 2/0", fwd_a, fwd_b); end
    mem_stall = 1'b0;
    tick();
    checks++; if (fwd_a !== 2'd3 || fwd_b !== 2'd2) begin errors++; $display("FAIL ms_resume got %0d/%0d want 3/2", fwd_a, fwd_b); end
    idle(3);
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);   // HLT
    tick();
    nop();
    tick();
    mem_stall = 1'b1;
    repeat (4) tick();
    checks++; if (hlt !== 1'b0 || bubble !== 1'b0) begin errors++; $display("FAIL ms_drain got hlt=%0b bubble=%0b want 0/0", hlt, bubble); end
    mem_stall = 1'b0;
    tick();
    checks++; if (hlt !== 1'b0) begin errors++; $display("FAIL ms_drain2 got %0b want 0", hlt); end
    tick();
    checks++; if (hlt !== 1'b1) begin errors++; $display("FAIL ms_halt got %0b want 1", hlt); end
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_drain();
    idle(3);
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    nop();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || hlt !== 1'b0) begin errors++; $display("FAIL rmd_abort got stall=%0b hlt=%0b want 0/0", stall, hlt); end
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (hlt !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rmd_run got hlt=%0b stall=%0b want 0/0", hlt, stall); end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_zero_unused();
    test_branch_flush();
    test_halt_clean();
    test_halt_flush();
    test_mem_stall();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard, forwarding and halt-drain controller for the pipelined CPU. It keeps a shadow scoreboard of in-flight register writes for a pipeline of configurable depth and load latency. From it the unit produces stall, bubble and flush controls, registered per-operand forwarding selects for the EX-stage muxes, and a sticky `hlt` once an HLT instruction has fully retired. It sits beside the ID stage, is fed by decode and the registered branch-taken signal, and replaces the fixed two-stage load-use and forwarding logic.

## Interface
- `REG_W`, 4: register-specifier width.
- `DEPTH`, 3: shadow stages after ID (1 = EX … `DEPTH` = WB); legal 2..8.
- `LOAD_LAT`, 1: extra stages a load result lags an ALU result; legal 0..`DEPTH`-2.
- `ZERO_REG`, 1: 1 means register 0 never matches (hardwired zero).
- `CNT_W`, 16: hazard-stall counter width.
- `FWD_W`, derived: `$clog2(DEPTH+1)`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  `REG_W`  ID source specifiers.
- `id_rs_used`, `id_rt_used`  in  1  source actually read.
- `id_rd`  in  `REG_W`  ID destination.
- `id_regwrite`, `id_memread`, `id_hlt`  in  1  ID decode flags.
- `br_taken`  in  1  registered taken-branch from EX (one cycle after the branch was in EX).
- `mem_stall`  in  1  global freeze request from memory.
- `stall`  out  1  hold PC and IF/ID (combinational).
- `bubble`  out  1  load NOP into ID/EX (combinational).
- `flush`  out  1  clear IF/ID and ID/EX (combinational).
- `fwd_a`, `fwd_b`  out  `FWD_W`  registered EX forward select; 0 = register-file value, k = shadow stage k result.
- `hlt`  out  1  registered, sticky halt.
- `stall_cnt`  out  `CNT_W`  saturating count of hazard-stall cycles.

## Operation
- Shadow entry fields: `v`, `rd`, `rw`, `ld`, `hl`. The entries shift 1→`DEPTH` each non-frozen cycle; the entry at `DEPTH` retires. The register file is write-through, so stage `DEPTH` is never matched.
- Match rule: source s of ID matches entry k (1 ≤ k ≤ `DEPTH`-1) when `v & rw & rd==s & s_used`, excluding s==0 when `ZERO_REG`=1. The youngest (smallest k) match wins.
- Result availability stage: 2 for ALU results, 2+`LOAD_LAT` for loads.
- Hazard: a winning match at k with k+1 < avail stage → `hz`=1.
- Priority, highest first:
  - `mem_stall`: `stall`=1, `bubble`=0, `flush`=0. Nothing shifts, and `fwd_*`, FSM and counter hold.
  - `br_taken`: `flush`=1 and `stall`=0. The entry inserted at stage 1 is invalid, and the old stage 1 is discarded (it becomes invalid as it shifts to 2).
  - `hz` with `id_valid` in RUN: `stall`=1, `bubble`=1, insert invalid entry, `stall_cnt`++ (saturating).
  - Otherwise: insert the ID entry (valid = `id_valid`).
- `fwd_a`/`fwd_b` register on each non-frozen edge:
  - k+1 of the winning match when ID advances into EX.
  - 0 on bubble, flush, no match, or an unused source.
- Halt FSM:
  - RUN → DRAIN when an HLT is inserted into stage 1. The drain counter loads `DEPTH`.
  - DRAIN: `stall`=1 and `bubble`=1 every cycle; the counter decrements on non-frozen cycles.
  - DRAIN → RUN if `flush` occurs while the HLT entry is at stage 1 (speculative HLT killed).
  - DRAIN → HALTED when the counter reaches 0.
  - HALTED: `hlt`=1, `stall`=1, `bubble`=1, until reset.
- Reset (asynchronous, `rst_n`=0):
  - All entries invalid; FSM RUN; counters 0.
  - `fwd_a`=`fwd_b`=0, `hlt`=0, `stall_cnt`=0.
  - Combinational outputs 0 with inputs idle.

## Timing
- `stall`/`bubble`/`flush` are combinational from same-cycle inputs and current state; there is no registered latency.
- `fwd_*` take effect in the cycle the consumer is in EX, one edge after the decision.
- Load-use distance 1 with `LOAD_LAT`=1: exactly 1 stall cycle. In general a load at stage k stalls for `LOAD_LAT`+1-k cycles.
- `hlt` rises `DEPTH` non-frozen cycles after HLT leaves ID.
- A simultaneous `hz` and `br_taken` gives flush only; the stall counter is unchanged.
- Reset mid-drain aborts to RUN immediately.

## Test plan
- ALU chain, DEPTH=3: `ADD r1`, then `ADD r2=r1+r3`, then `SUB r4=r1-r2`.
  - 2nd instr EX: `fwd_a`=2.
  - 3rd instr EX: `fwd_a`=3, `fwd_b`=2.
  - No stalls; `stall_cnt`=0.
- Load-use: `LW r5`, then `ADD r6=r5+r5`.
  - One cycle `stall`=`bubble`=1, then `fwd_a`=`fwd_b`=3.
  - `stall_cnt`=1.
  - Repeat with `LOAD_LAT`=0: no stall, fwd=2.
- R0 and unused source: producer writes r0, consumer reads r0 → fwd 0, no stall. Consumer with `id_rt_used`=0 matching rd → `fwd_b`=0.
- Branch flush during hazard: load-use hazard with `br_taken`=1 in the same cycle.
  - `flush`=1, `stall`=0, `stall_cnt` unchanged.
  - Next cycle the stage-1 entry is invalid (no fwd from it).
- Halt:
  - Clean HLT: `hlt`=1 exactly 3 cycles after leaving ID; `stall`=1 throughout.
  - HLT flushed at stage 1: returns to RUN, `hlt` stays 0.
- `mem_stall` held 4 cycles mid-sequence: `fwd_*`, drain counter and entries frozen; results identical to the no-freeze run, shifted by 4 cycles.
